// File: rtl/isa_pkg.sv
// ISA control table for the 16-bit core: opcodes, ALU encodings,
// the ID/EX control bundle, decode helpers and the ID stage state enum.
package isa_pkg;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHF_R = 5'b11010;
    localparam logic [4:0] OP_ALU_R = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    localparam logic [3:0] ALU_ROL  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_ROR  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_PASB = 4'b1000;
    localparam logic [3:0] ALU_SLBI = 4'b1001;
    localparam logic [3:0] ALU_BTR  = 4'b1010;
    localparam logic [3:0] ALU_SEQ  = 4'b1011;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_SLE  = 4'b1101;
    localparam logic [3:0] ALU_SCO  = 4'b1110;

    localparam logic [1:0] SRC_RT    = 2'b00;
    localparam logic [1:0] SRC_SIMM5 = 2'b01;
    localparam logic [1:0] SRC_ZIMM5 = 2'b10;
    localparam logic [1:0] SRC_IMM8  = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RS = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic       alu_inv_a;
        logic       alu_inv_b;
        logic       alu_cin;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_to_reg;
        logic       reg_to_pc;
    } ctrl_bundle_t;

    function automatic logic is_legal(input logic [4:0] op);
        return (op != OP_SIIC) && (op != OP_RTI);
    endfunction

    function automatic logic is_rfmt(input logic [4:0] op);
        return (op == OP_ALU_R) || (op == OP_SHF_R) ||
               (op[4:2] == 3'b111);
    endfunction

    function automatic logic uses_rs(input logic [4:0] op);
        return !((op == OP_J) || (op == OP_JAL) || (op == OP_HALT) ||
                 (op == OP_NOP) || (op == OP_LBI));
    endfunction

    function automatic logic uses_rt(input logic [4:0] op);
        return is_rfmt(op) || (op == OP_ST) || (op == OP_STU);
    endfunction

    function automatic logic [1:0] reg_dst_sel(input logic [4:0] op);
        logic [1:0] sel;
        sel = RD_RT;
        if (is_rfmt(op) || (op == OP_BTR))
            sel = RD_RD;
        else if ((op == OP_LBI) || (op == OP_SLBI) || (op == OP_STU))
            sel = RD_RS;
        return sel;
    endfunction

    function automatic ctrl_bundle_t decode(
        input logic [4:0] op,
        input logic [1:0] mode
    );
        ctrl_bundle_t c;
        c = '0;
        case (op)
            OP_ADDI: begin
                c.alu_op = ALU_ADD; c.alu_src = SRC_SIMM5;
                c.reg_write = 1'b1;
            end
            OP_SUBI: begin
                c.alu_op = ALU_ADD; c.alu_src = SRC_SIMM5;
                c.alu_inv_a = 1'b1; c.alu_cin = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_XORI: begin
                c.alu_op = ALU_XOR; c.alu_src = SRC_ZIMM5;
                c.reg_write = 1'b1;
            end
            OP_ANDNI: begin
                c.alu_op = ALU_AND; c.alu_src = SRC_ZIMM5;
                c.alu_inv_b = 1'b1; c.reg_write = 1'b1;
            end
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                c.alu_op = {2'b00, op[1:0]};
                c.alu_src = SRC_ZIMM5; c.reg_write = 1'b1;
            end
            OP_ST: begin
                c.alu_op = ALU_ADD; c.alu_src = SRC_SIMM5;
                c.mem_write = 1'b1;
            end
            OP_LD: begin
                c.alu_op = ALU_ADD; c.alu_src = SRC_SIMM5;
                c.mem_read = 1'b1; c.reg_write = 1'b1;
            end
            OP_STU: begin
                c.alu_op = ALU_ADD; c.alu_src = SRC_SIMM5;
                c.mem_write = 1'b1; c.reg_write = 1'b1;
            end
            OP_SLBI: begin
                c.alu_op = ALU_SLBI; c.alu_src = SRC_IMM8;
                c.reg_write = 1'b1;
            end
            OP_LBI: begin
                c.alu_op = ALU_PASB; c.alu_src = SRC_IMM8;
                c.reg_write = 1'b1;
            end
            OP_BTR: begin
                c.alu_op = ALU_BTR; c.reg_write = 1'b1;
            end
            OP_ALU_R: begin
                c.reg_write = 1'b1;
                unique case (mode)
                    2'b00: c.alu_op = ALU_ADD;
                    2'b01: begin
                        c.alu_op = ALU_ADD;
                        c.alu_inv_a = 1'b1; c.alu_cin = 1'b1;
                    end
                    2'b10: c.alu_op = ALU_XOR;
                    default: begin
                        c.alu_op = ALU_AND; c.alu_inv_b = 1'b1;
                    end
                endcase
            end
            OP_SHF_R: begin
                c.alu_op = {2'b00, mode}; c.reg_write = 1'b1;
            end
            OP_SEQ: begin c.alu_op = ALU_SEQ; c.reg_write = 1'b1; end
            OP_SLT: begin c.alu_op = ALU_SLT; c.reg_write = 1'b1; end
            OP_SLE: begin c.alu_op = ALU_SLE; c.reg_write = 1'b1; end
            OP_SCO: begin c.alu_op = ALU_SCO; c.reg_write = 1'b1; end
            // branch condition travels in alu_op[1:0]
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
                c.branch = 1'b1; c.alu_op = {2'b00, op[1:0]};
            end
            OP_J: c.jump = 1'b1;
            OP_JR: begin
                c.jump = 1'b1; c.reg_to_pc = 1'b1;
                c.alu_op = ALU_ADD; c.alu_src = SRC_IMM8;
            end
            OP_JAL: begin
                c.jump = 1'b1; c.pc_to_reg = 1'b1; c.reg_write = 1'b1;
            end
            OP_JALR: begin
                c.jump = 1'b1; c.reg_to_pc = 1'b1;
                c.pc_to_reg = 1'b1; c.reg_write = 1'b1;
                c.alu_op = ALU_ADD; c.alu_src = SRC_IMM8;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Load-use hazard compare between the decoding instruction and
// the load currently in EX.
module id_hazard_unit #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  instr_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_wr_reg,
    input  logic                  use_rs,
    input  logic                  use_rt,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  flush,
    input  logic                  run,
    output logic                  hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = use_rs && (rs == ex_wr_reg);
    assign rt_hit = use_rt && (rt == ex_wr_reg);

    assign hazard = instr_valid && ex_mem_read && (rs_hit || rt_hit) &&
                    !flush && run;

endmodule

// File: rtl/id_ctrl_stage.sv
// Pipelined ID stage: decode into the ID/EX register with stall,
// flush, load-use bubbles and a halt/illegal drain FSM.
module id_ctrl_stage
    import isa_pkg::*;
#(
    parameter int REG_ADDR_W   = 3,
    parameter int LINK_REG     = 7,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           instr_i,
    input  logic                  instr_valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_wr_reg_i,
    output logic                  hazard_stall_o,
    output logic                  valid_o,
    output logic [3:0]            alu_op_o,
    output logic [1:0]            alu_src_o,
    output logic                  alu_inv_a_o,
    output logic                  alu_inv_b_o,
    output logic                  alu_cin_o,
    output logic                  jump_o,
    output logic                  branch_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  reg_write_o,
    output logic                  pc_to_reg_o,
    output logic                  reg_to_pc_o,
    output logic [REG_ADDR_W-1:0] rs_o,
    output logic [REG_ADDR_W-1:0] rt_o,
    output logic [REG_ADDR_W-1:0] wr_reg_o,
    output logic                  halted_o,
    output logic                  err_o
);

    logic [4:0]            opcode;
    logic [1:0]            mode;
    ctrl_bundle_t          dec;
    logic [REG_ADDR_W-1:0] rs_d;
    logic [REG_ADDR_W-1:0] rt_d;
    logic [REG_ADDR_W-1:0] wr_d;
    logic                  stop_op;
    logic                  accept;

    state_t                state;
    logic [3:0]            cnt;
    ctrl_bundle_t          ctrl_q;
    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [REG_ADDR_W-1:0] rt_q;
    logic [REG_ADDR_W-1:0] wr_q;
    logic                  halted_q;
    logic                  err_q;

    assign opcode  = instr_i[15:11];
    assign mode    = instr_i[1:0];
    assign dec     = decode(opcode, mode);
    assign rs_d    = REG_ADDR_W'(instr_i[10:8]);
    assign rt_d    = REG_ADDR_W'(instr_i[7:5]);
    assign stop_op = (opcode == OP_HALT) || !is_legal(opcode);

    always_comb begin
        wr_d = '0;
        if (dec.reg_write) begin
            if ((opcode == OP_JAL) || (opcode == OP_JALR))
                wr_d = REG_ADDR_W'(LINK_REG);
            else begin
                unique case (reg_dst_sel(opcode))
                    RD_RD:   wr_d = REG_ADDR_W'(instr_i[4:2]);
                    RD_RS:   wr_d = REG_ADDR_W'(instr_i[10:8]);
                    default: wr_d = REG_ADDR_W'(instr_i[7:5]);
                endcase
            end
        end
    end

    id_hazard_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .instr_valid(instr_valid_i),
        .ex_mem_read(ex_mem_read_i),
        .ex_wr_reg  (ex_wr_reg_i),
        .use_rs     (uses_rs(opcode)),
        .use_rt     (uses_rt(opcode)),
        .rs         (rs_d),
        .rt         (rt_d),
        .flush      (flush_i),
        .run        (state == RUN),
        .hazard     (hazard_stall_o)
    );

    assign accept = instr_valid_i && !stall_i && !flush_i &&
                    !hazard_stall_o && (state == RUN);

    // flush, hazard, non-RUN and idle all collapse to a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            wr_q    <= '0;
        end else if (!stall_i) begin
            if (accept && !stop_op) begin
                valid_q <= 1'b1;
                ctrl_q  <= dec;
                rs_q    <= rs_d;
                rt_q    <= rt_d;
                wr_q    <= wr_d;
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                rs_q    <= '0;
                rt_q    <= '0;
                wr_q    <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            cnt      <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (!stall_i) begin
            unique case (state)
                RUN: begin
                    if (accept && stop_op) begin
                        state <= DRAIN;
                        cnt   <= 4'(DRAIN_CYCLES);
                        if (!is_legal(opcode))
                            err_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (flush_i) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt == 4'd1) begin
                        state    <= HALTED;
                        cnt      <= '0;
                        halted_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    assign valid_o     = valid_q;
    assign alu_op_o    = ctrl_q.alu_op;
    assign alu_src_o   = ctrl_q.alu_src;
    assign alu_inv_a_o = ctrl_q.alu_inv_a;
    assign alu_inv_b_o = ctrl_q.alu_inv_b;
    assign alu_cin_o   = ctrl_q.alu_cin;
    assign jump_o      = ctrl_q.jump;
    assign branch_o    = ctrl_q.branch;
    assign mem_read_o  = ctrl_q.mem_read;
    assign mem_write_o = ctrl_q.mem_write;
    assign reg_write_o = ctrl_q.reg_write;
    assign pc_to_reg_o = ctrl_q.pc_to_reg;
    assign reg_to_pc_o = ctrl_q.reg_to_pc;
    assign rs_o        = rs_q;
    assign rt_o        = rt_q;
    assign wr_reg_o    = wr_q;
    assign halted_o    = halted_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed scenarios plus randomized
// traffic against a mnemonic-level reference model.
module tb_id_ctrl_stage;

    localparam int W    = 3;
    localparam int LINK = 7;
    localparam int DC   = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  instr;
    logic         valid;
    logic         stall;
    logic         flush;
    logic         ex_mr;
    logic [W-1:0] ex_wr;
    logic         hazard_stall_o;
    logic         valid_o;
    logic [3:0]   alu_op_o;
    logic [1:0]   alu_src_o;
    logic         alu_inv_a_o, alu_inv_b_o, alu_cin_o;
    logic         jump_o, branch_o, mem_read_o, mem_write_o;
    logic         reg_write_o, pc_to_reg_o, reg_to_pc_o;
    logic [W-1:0] rs_o, rt_o, wr_reg_o;
    logic         halted_o, err_o;

    int passed = 0;
    int total  = 0;

    id_ctrl_stage #(
        .REG_ADDR_W(W), .LINK_REG(LINK), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr),
        .instr_valid_i(valid), .stall_i(stall), .flush_i(flush),
        .ex_mem_read_i(ex_mr), .ex_wr_reg_i(ex_wr),
        .hazard_stall_o(hazard_stall_o), .valid_o(valid_o),
        .alu_op_o(alu_op_o), .alu_src_o(alu_src_o),
        .alu_inv_a_o(alu_inv_a_o), .alu_inv_b_o(alu_inv_b_o),
        .alu_cin_o(alu_cin_o), .jump_o(jump_o), .branch_o(branch_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .reg_write_o(reg_write_o), .pc_to_reg_o(pc_to_reg_o),
        .reg_to_pc_o(reg_to_pc_o), .rs_o(rs_o), .rt_o(rt_o),
        .wr_reg_o(wr_reg_o), .halted_o(halted_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] obs();
        return {valid_o, alu_op_o, alu_src_o, alu_inv_a_o, alu_inv_b_o,
                alu_cin_o, jump_o, branch_o, mem_read_o, mem_write_o,
                reg_write_o, pc_to_reg_o, reg_to_pc_o,
                rs_o, rt_o, wr_reg_o};
    endfunction

    // expected registered bundle for an accepted, non-stopping instr
    function automatic logic [25:0] ref_bundle(input logic [15:0] ins);
        logic [4:0] op;
        logic [1:0] m;
        logic [3:0] a;
        logic [1:0] s;
        logic ia, ib, ci, j, b, mr, mw, rw, pr, rp;
        logic [2:0] wr;
        op = ins[15:11]; m = ins[1:0];
        a = 0; s = 0; ia = 0; ib = 0; ci = 0; j = 0; b = 0;
        mr = 0; mw = 0; rw = 0; pr = 0; rp = 0; wr = 0;
        case (op)
            5'b01000: begin a = 4; s = 1; rw = 1; wr = ins[7:5]; end
            5'b01001: begin
                a = 4; s = 1; ia = 1; ci = 1; rw = 1; wr = ins[7:5];
            end
            5'b01010: begin a = 7; s = 2; rw = 1; wr = ins[7:5]; end
            5'b01011: begin
                a = 5; s = 2; ib = 1; rw = 1; wr = ins[7:5];
            end
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                a = 4'(op - 5'b10100); s = 2; rw = 1; wr = ins[7:5];
            end
            5'b10000: begin a = 4; s = 1; mw = 1; end
            5'b10001: begin
                a = 4; s = 1; mr = 1; rw = 1; wr = ins[7:5];
            end
            5'b10011: begin
                a = 4; s = 1; mw = 1; rw = 1; wr = ins[10:8];
            end
            5'b10010: begin a = 9; s = 3; rw = 1; wr = ins[10:8]; end
            5'b11000: begin a = 8; s = 3; rw = 1; wr = ins[10:8]; end
            5'b11001: begin a = 10; rw = 1; wr = ins[4:2]; end
            5'b11011: begin
                rw = 1; wr = ins[4:2];
                if (m == 0) a = 4;
                else if (m == 1) begin a = 4; ia = 1; ci = 1; end
                else if (m == 2) a = 7;
                else begin a = 5; ib = 1; end
            end
            5'b11010: begin a = {2'b00, m}; rw = 1; wr = ins[4:2]; end
            5'b11100: begin a = 11; rw = 1; wr = ins[4:2]; end
            5'b11101: begin a = 12; rw = 1; wr = ins[4:2]; end
            5'b11110: begin a = 13; rw = 1; wr = ins[4:2]; end
            5'b11111: begin a = 14; rw = 1; wr = ins[4:2]; end
            5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
                b = 1; a = 4'(op - 5'b01100);
            end
            5'b00100: j = 1;
            5'b00101: begin j = 1; rp = 1; a = 4; s = 3; end
            5'b00110: begin j = 1; pr = 1; rw = 1; wr = 3'(LINK); end
            5'b00111: begin
                j = 1; rp = 1; pr = 1; rw = 1; a = 4; s = 3;
                wr = 3'(LINK);
            end
            default: ;
        endcase
        return {1'b1, a, s, ia, ib, ci, j, b, mr, mw, rw, pr, rp,
                ins[10:8], ins[7:5], wr};
    endfunction

    function automatic logic ref_urs(input logic [4:0] op);
        return !(op inside {5'b00100, 5'b00110, 5'b00000,
                            5'b00001, 5'b11000});
    endfunction

    function automatic logic ref_urt(input logic [4:0] op);
        return op inside {5'b11011, 5'b11010, 5'b11100, 5'b11101,
                          5'b11110, 5'b11111, 5'b10000, 5'b10011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr = 16'h0800; valid = 0; stall = 0; flush = 0;
        ex_mr = 0; ex_wr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        total++;
        if (obs() !== 26'd0 || halted_o !== 0 || err_o !== 0)
            $display("FAIL reset_state: got %h/%b/%b want 0",
                     obs(), halted_o, err_o);
        else passed++;
        rst_n = 1;
        tick();
        total++;
        if (obs() !== 26'd0)
            $display("FAIL reset_idle: got %h want 0", obs());
        else passed++;
    endtask

    task automatic test_addi();
        instr = 16'h4125; valid = 1;
        #1;
        total++;
        if (hazard_stall_o !== 0)
            $display("FAIL addi_hz: got %b want 0", hazard_stall_o);
        else passed++;
        tick();
        total++;
        if (valid_o !== 1 || alu_op_o !== 4'b0100 || alu_src_o !== 2'b01 ||
            reg_write_o !== 1 || wr_reg_o !== 3'd1 || rs_o !== 3'd1)
            $display("FAIL addi: got %h want v1 op4 src1 rw1 wr1", obs());
        else passed++;
    endtask

    task automatic test_hazard();
        ex_mr = 1; ex_wr = 3; instr = 16'hDB08; valid = 1;
        #1;
        total++;
        if (hazard_stall_o !== 1)
            $display("FAIL hz_detect: got %b want 1", hazard_stall_o);
        else passed++;
        tick();
        total++;
        if (valid_o !== 0 || obs() !== 26'd0)
            $display("FAIL hz_bubble: got %h want 0", obs());
        else passed++;
        ex_mr = 0;
        #1;
        total++;
        if (hazard_stall_o !== 0)
            $display("FAIL hz_clear: got %b want 0", hazard_stall_o);
        else passed++;
        tick();
        total++;
        if (valid_o !== 1 || alu_op_o !== 4'b0100 || wr_reg_o !== 3'd2 ||
            reg_write_o !== 1)
            $display("FAIL hz_issue: got %h want v1 op4 wr2", obs());
        else passed++;
    endtask

    task automatic test_jal();
        instr = 16'h3123; valid = 1;
        tick();
        total++;
        if (valid_o !== 1 || wr_reg_o !== 3'd7 || pc_to_reg_o !== 1 ||
            jump_o !== 1 || reg_write_o !== 1)
            $display("FAIL jal: got %h want wr7 p2r1 j1 rw1", obs());
        else passed++;
    endtask

    task automatic test_stall_flush();
        logic [15:0] sub;
        sub = {5'b11011, 3'd1, 3'd5, 3'd2, 2'b01};
        instr = sub; valid = 1;
        tick();
        total++;
        if (obs() !== ref_bundle(sub) || alu_inv_a_o !== 1 ||
            alu_cin_o !== 1)
            $display("FAIL sub: got %h want %h", obs(), ref_bundle(sub));
        else passed++;
        stall = 1;
        for (int k = 0; k < 2; k++) begin
            instr = 16'($urandom);
            tick();
            total++;
            if (obs() !== ref_bundle(sub))
                $display("FAIL stall_hold%0d: got %h want %h",
                         k, obs(), ref_bundle(sub));
            else passed++;
        end
        stall = 0; flush = 1; instr = 16'h4125;
        tick();
        total++;
        if (obs() !== 26'd0)
            $display("FAIL flush_bubble: got %h want 0", obs());
        else passed++;
        flush = 0;
    endtask

    task automatic test_halt_drain();
        logic [4:0] seq_stall;
        seq_stall = 5'b00100;
        instr = 16'h0000; valid = 1;
        tick();
        total++;
        if (valid_o !== 0 || halted_o !== 0)
            $display("FAIL halt_accept: got v%b h%b want 0 0",
                     valid_o, halted_o);
        else passed++;
        instr = 16'h4125;
        for (int k = 1; k <= 4; k++) begin
            stall = seq_stall[k];
            tick();
            total++;
            if (halted_o !== (k == 4) || valid_o !== 0)
                $display("FAIL drain_c%0d: got h%b v%b want h%b v0",
                         k, halted_o, valid_o, k == 4);
            else passed++;
        end
        stall = 0; flush = 1;
        tick();
        total++;
        if (halted_o !== 1)
            $display("FAIL halt_flush: got %b want 1", halted_o);
        else passed++;
        flush = 0;
        tick();
        total++;
        if (valid_o !== 0 || halted_o !== 1)
            $display("FAIL halt_absorb: got v%b h%b want v0 h1",
                     valid_o, halted_o);
        else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        instr = 16'h1000; valid = 1;
        tick();
        total++;
        if (err_o !== 1 || valid_o !== 0)
            $display("FAIL illegal_err: got e%b v%b want e1 v0",
                     err_o, valid_o);
        else passed++;
        flush = 1; instr = 16'h4125;
        tick();
        total++;
        if (err_o !== 1 || halted_o !== 0)
            $display("FAIL drain_flush: got e%b h%b want e1 h0",
                     err_o, halted_o);
        else passed++;
        flush = 0;
        tick();
        total++;
        if (valid_o !== 1 || alu_op_o !== 4'b0100 || err_o !== 1)
            $display("FAIL post_flush_addi: got %h e%b want v1 op4 e1",
                     obs(), err_o);
        else passed++;
        rst_n = 0;
        #2;
        total++;
        if (err_o !== 0 || valid_o !== 0)
            $display("FAIL async_rst: got e%b v%b want 0 0",
                     err_o, valid_o);
        else passed++;
        tick();
        rst_n = 1;
        idle_inputs();
    endtask

    task automatic test_random();
        int left;
        logic err_m;
        logic [25:0] out_m;
        logic hz, acc, stop;
        logic [4:0] op;
        do_reset();
        left = -1; err_m = 0; out_m = 0;
        for (int i = 0; i < 600; i++) begin
            instr = 16'($urandom);
            op = instr[15:11];
            if (op inside {5'b00000, 5'b00010, 5'b00011} &&
                $urandom_range(0, 5) != 0)
                instr[15:11] = 5'b11011;
            op = instr[15:11];
            valid = ($urandom_range(0, 9) < 8);
            stall = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 9) == 0);
            ex_mr = 1'($urandom_range(0, 1));
            ex_wr = 3'($urandom);
            hz = valid && ex_mr && !flush && (left < 0) &&
                 ((ref_urs(op) && instr[10:8] == ex_wr) ||
                  (ref_urt(op) && instr[7:5] == ex_wr));
            #1;
            total++;
            if (hazard_stall_o !== hz)
                $display("FAIL rnd_hz[%0d]: got %b want %b",
                         i, hazard_stall_o, hz);
            else passed++;
            if (!stall) begin
                acc = valid && !flush && !hz && (left < 0);
                stop = op inside {5'b00000, 5'b00010, 5'b00011};
                out_m = (acc && !stop) ? ref_bundle(instr) : 26'd0;
                if (left < 0) begin
                    if (acc && stop) begin
                        left = DC;
                        if (op != 5'b00000) err_m = 1;
                    end
                end else if (left > 0) begin
                    if (flush) left = -1;
                    else left--;
                end
            end
            tick();
            total++;
            if (obs() !== out_m || halted_o !== (left == 0) ||
                err_o !== err_m)
                $display("FAIL rnd_out[%0d]: got %h h%b e%b want %h h%b e%b",
                         i, obs(), halted_o, err_o, out_m, left == 0, err_m);
            else passed++;
            if (left == 0 && $urandom_range(0, 3) == 0) begin
                do_reset();
                left = -1; err_m = 0; out_m = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_hazard();
        test_jal();
        test_stall_flush();
        test_halt_drain();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ctrl_stage.md
Name: id_ctrl_stage

Overview:
- Pipelined successor to the combinational control decoder.
- Decodes one instruction per cycle and registers the full control bundle plus register specifiers into the ID/EX boundary.
- Adds stall hold, flush bubbles, load-use hazard detection, and a halt/illegal-opcode drain state machine.
- Sits between the IF/ID register and the execute stage.

Parameters:
- REG_ADDR_W, 3, register-specifier width (register file depth = 2**REG_ADDR_W).
- LINK_REG, 7, destination register for JAL/JALR.
- DRAIN_CYCLES, 3, unstalled cycles after HALT acceptance before halted_o asserts (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_i  in  16  instruction from IF/ID; [15:11] opcode, [1:0] mode.
- instr_valid_i  in  1  instr_i holds a real instruction.
- stall_i  in  1  downstream hold: freeze all registered outputs and the FSM.
- flush_i  in  1  branch/jump redirect: kill the current decode.
- ex_mem_read_i  in  1  instruction currently in EX is a load.
- ex_wr_reg_i  in  REG_ADDR_W  destination register of the EX-stage load.
- hazard_stall_o  out  1  combinational: upstream must hold PC and IF/ID this cycle.
- valid_o  out  1  registered bundle is a real instruction.
- alu_op_o  out  4  ALU operation (team ALU encoding).
- alu_src_o  out  2  ALU B-operand select.
- alu_inv_a_o, alu_inv_b_o, alu_cin_o  out  1 each  ALU modifiers.
- jump_o, branch_o, mem_read_o, mem_write_o, reg_write_o, pc_to_reg_o, reg_to_pc_o  out  1 each  control bits.
- rs_o, rt_o, wr_reg_o  out  REG_ADDR_W each  source and destination register specifiers.
- halted_o  out  1  sticky; pipeline has drained after HALT or an illegal opcode.
- err_o  out  1  sticky; an illegal opcode was accepted.

Behaviour:
Reset:
- All outputs are 0, FSM is in RUN, drain counter is 0.

Decode:
- Combinational decode of instr_i into a bundle, per the ISA control table in isa_pkg.
- Every don't-care field is driven to 0; no X propagates to outputs.
- rs = instr[10:8]; rt = instr[7:5].
- wr_reg selection:
  - RegDst 00: instr[7:5].
  - RegDst 01: instr[4:2].
  - RegDst 10: instr[10:8].
  - JAL/JALR: LINK_REG.
- Register-read use flags come from isa_pkg:
  - uses_rs: all except J, JAL, HALT, NOP, LBI.
  - uses_rt: R-format, ST, STU.

Hazard:
- hazard_stall_o = instr_valid_i & ex_mem_read_i & ((uses_rs & rs==ex_wr_reg_i) | (uses_rt & rt==ex_wr_reg_i)) & !flush_i & state==RUN.

Per-edge priority (first match wins):
1. stall_i: hold all registers, FSM and counter.
2. flush_i: load a bubble (valid_o=0, all control bits 0); FSM in DRAIN returns to RUN, counter cleared.
3. hazard_stall_o: load a bubble.
4. state != RUN: load a bubble.
5. instr_valid_i: load the decoded bundle, valid_o=1.
6. Otherwise: load a bubble.

Acceptance:
- An instruction is accepted when case 5 loads it.

FSM:
- RUN → DRAIN on accepting HALT (opcode 00000) or an illegal opcode.
  - The HALT/illegal instruction itself is emitted as a bubble (valid_o=0).
  - Illegal opcode also sets err_o.
  - Counter loads DRAIN_CYCLES.
- DRAIN: counter decrements on each unstalled cycle. When counter==1 at an unstalled edge, go to HALTED and assert halted_o.
- HALTED: absorbing. Only bubbles are emitted; flush_i is ignored; exit only by reset.
- Flush in DRAIN returns to RUN, but err_o is NOT cleared (sticky).
- Asserting rst_n low mid-drain clears everything asynchronously.

Latency:
- Bundle appears 1 cycle after acceptance.

Decomposition:
- isa_pkg holds:
  - opcode localparams;
  - ALU op encodings;
  - the ctrl_bundle_t struct (all control outputs);
  - the decode function;
  - the uses_rs/uses_rt functions;
  - the state enum {RUN, DRAIN, HALTED}.
- One sub-module, id_hazard_unit: the combinational load-use compare.
- The registers and FSM stay in id_ctrl_stage.

Test Plan:
1. ADDI 0x4125 (rd=1, rs=1), valid, no stall → next cycle valid_o=1, alu_op_o=0100, alu_src_o=01, reg_write_o=1, wr_reg_o=1.
2. ex_mem_read_i=1, ex_wr_reg_i=3; ADD rs=3 (0xDB08) → hazard_stall_o=1 same cycle, bubble next cycle. Drop ex_mem_read_i → instruction issues with valid_o=1, alu_op_o=0100.
3. JAL → wr_reg_o=7, pc_to_reg_o=1, jump_o=1, reg_write_o=1.
4. Registered SUB, then stall_i=1 for 2 cycles while instr_i changes → outputs unchanged. Then flush_i with stall_i=0 → valid_o=0, all controls 0.
5. HALT accepted, DRAIN_CYCLES=3, with one stall cycle mid-drain → halted_o rises 4 cycles after acceptance. A later flush_i does not clear halted_o.
6. Illegal opcode → err_o=1 next cycle. flush_i during DRAIN → state RUN, err_o stays 1. ADDI then issues normally. Asserting rst_n low clears err_o asynchronously.
